// File: rtl/ign_pkg.sv
// Shared types, default widths and delay helper for the multi-channel ignition scheduler.
package ign_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DWELL
    } ch_state_t;

    localparam int unsigned DEF_NUM_CH       = 4;
    localparam int unsigned DEF_PHASE_W      = 16;
    localparam int unsigned DEF_PERIOD_W     = 32;
    localparam int unsigned DEF_FRAC_SHIFT   = 8;
    localparam int unsigned DEF_LAT_COMP     = 4;
    localparam int unsigned DEF_TOOTH_MARGIN = 20;
    localparam int unsigned DEF_MAX_DWELL    = 200000;

    // Wide enough to hold tooth_period*phase_diff before saturation.
    localparam int unsigned SAT_W = 64;
    typedef logic [SAT_W-1:0] sat_t;

    // Subtract latency compensation, floor at zero, ceiling at the counter maximum.
    function automatic sat_t sat_delay(input sat_t raw, input sat_t lat, input sat_t ceil);
        sat_t d;
        if (raw <= lat) d = '0;
        else            d = raw - lat;
        if (d > ceil)   d = ceil;
        return d;
    endfunction

endpackage

// File: rtl/ign_sched_ch.sv
// One ignition channel: window check, spark delay, dwell clamp and WAIT/DWELL countdown.
module ign_sched_ch
    import ign_pkg::*;
#(
    parameter int unsigned PHASE_W      = DEF_PHASE_W,
    parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
    parameter int unsigned FRAC_SHIFT   = DEF_FRAC_SHIFT,
    parameter int unsigned LAT_COMP     = DEF_LAT_COMP,
    parameter int unsigned TOOTH_MARGIN = DEF_TOOTH_MARGIN,
    parameter int unsigned MAX_DWELL    = DEF_MAX_DWELL
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trigger,
    input  logic [PHASE_W-1:0]  eng_phase,
    input  logic [PHASE_W-1:0]  next_tooth_width,
    input  logic [PERIOD_W-1:0] tooth_period,
    input  logic [PHASE_W-1:0]  timing,
    input  logic [PERIOD_W-1:0] dwell_cycles,
    input  logic                ch_enable,
    output logic                coil,
    output logic                spark_pulse,
    output logic                busy,
    output logic                overdwell_err
);

    localparam int unsigned         PROD_W = PERIOD_W + PHASE_W;
    localparam int unsigned         WIN_W  = PHASE_W + 2;
    localparam logic [PERIOD_W-1:0] MAX_W  = PERIOD_W'(MAX_DWELL);

    ch_state_t           state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] dwell_q;

    logic [WIN_W-1:0]    win_hi;
    logic                in_window;
    logic [PHASE_W-1:0]  diff;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   scaled;
    logic [PERIOD_W-1:0] delay;
    logic                clamp;
    logic [PERIOD_W-1:0] dwell_w;

    // Arming decision, spark delay and clamped dwell from the trigger-cycle inputs.
    always_comb begin
        win_hi    = WIN_W'(eng_phase) + WIN_W'(next_tooth_width) + WIN_W'(TOOTH_MARGIN);
        in_window = ch_enable && (timing > eng_phase) && (WIN_W'(timing) <= win_hi);
        diff      = timing - eng_phase;
        prod      = PROD_W'(tooth_period) * PROD_W'(diff);
        scaled    = prod >> FRAC_SHIFT;
        delay     = PERIOD_W'(sat_delay(SAT_W'(scaled), SAT_W'(LAT_COMP), SAT_W'({PERIOD_W{1'b1}})));
        clamp     = dwell_cycles > MAX_W;
        dwell_w   = clamp ? MAX_W : dwell_cycles;
    end

    // Channel FSM with registered coil/spark/busy outputs.
    // WAIT counts the D-W lead-in, DWELL counts the charge time; spark fires on the cycle coil drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            dwell_q       <= '0;
            coil          <= 1'b0;
            spark_pulse   <= 1'b0;
            busy          <= 1'b0;
            overdwell_err <= 1'b0;
        end else begin
            spark_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger && in_window) begin
                        if (clamp) overdwell_err <= 1'b1;
                        dwell_q <= dwell_w;
                        if (delay > dwell_w) begin
                            state <= WAIT;
                            cnt   <= delay - dwell_w;
                            busy  <= 1'b1;
                        end else if (delay != '0) begin
                            state <= DWELL;
                            cnt   <= delay;
                            coil  <= 1'b1;
                            busy  <= 1'b1;
                        end else begin
                            spark_pulse <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!ch_enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == PERIOD_W'(1)) begin
                        if (dwell_q == '0) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            spark_pulse <= 1'b1;
                        end else begin
                            state <= DWELL;
                            cnt   <= dwell_q;
                            coil  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - PERIOD_W'(1);
                    end
                end
                DWELL: begin
                    if (!ch_enable || cnt == PERIOD_W'(1)) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        coil        <= 1'b0;
                        busy        <= 1'b0;
                        spark_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt - PERIOD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    coil  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ign_sched_multi.sv
// Multi-channel ignition scheduler: one independent ign_sched_ch per coil.
module ign_sched_multi
    import ign_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned PHASE_W      = DEF_PHASE_W,
    parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
    parameter int unsigned FRAC_SHIFT   = DEF_FRAC_SHIFT,
    parameter int unsigned LAT_COMP     = DEF_LAT_COMP,
    parameter int unsigned TOOTH_MARGIN = DEF_TOOTH_MARGIN,
    parameter int unsigned MAX_DWELL    = DEF_MAX_DWELL
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         trigger,
    input  logic [PHASE_W-1:0]           eng_phase,
    input  logic [PHASE_W-1:0]           next_tooth_width,
    input  logic [PERIOD_W-1:0]          tooth_period,
    input  logic [NUM_CH*PHASE_W-1:0]    timing,
    input  logic [NUM_CH*PERIOD_W-1:0]   dwell_cycles,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic [NUM_CH-1:0]            coil,
    output logic [NUM_CH-1:0]            spark_pulse,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            overdwell_err
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ign_sched_ch #(
            .PHASE_W      (PHASE_W),
            .PERIOD_W     (PERIOD_W),
            .FRAC_SHIFT   (FRAC_SHIFT),
            .LAT_COMP     (LAT_COMP),
            .TOOTH_MARGIN (TOOTH_MARGIN),
            .MAX_DWELL    (MAX_DWELL)
        ) u_ch (
            .clk              (clk),
            .reset            (reset),
            .trigger          (trigger),
            .eng_phase        (eng_phase),
            .next_tooth_width (next_tooth_width),
            .tooth_period     (tooth_period),
            .timing           (timing[i*PHASE_W +: PHASE_W]),
            .dwell_cycles     (dwell_cycles[i*PERIOD_W +: PERIOD_W]),
            .ch_enable        (ch_enable[i]),
            .coil             (coil[i]),
            .spark_pulse      (spark_pulse[i]),
            .busy             (busy[i]),
            .overdwell_err    (overdwell_err[i])
        );
    end

endmodule

// File: tb/tb_ign_sched_multi.sv
// Self-checking bench for ign_sched_multi against an event-time reference model.
`timescale 1ns/1ps
module tb_ign_sched_multi;

    localparam int unsigned NCH  = 4;
    localparam int unsigned PW   = 16;
    localparam int unsigned TW   = 32;
    localparam int unsigned MAXD = 1000;
    localparam longint unsigned NEVER = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic trigger = 1'b0;
    logic [PW-1:0] eng_phase = '0;
    logic [PW-1:0] next_tooth_width = '0;
    logic [TW-1:0] tooth_period = '0;
    logic [NCH*PW-1:0] timing = '0;
    logic [NCH*TW-1:0] dwell_cycles = '0;
    logic [NCH-1:0] ch_enable = '0;
    logic [NCH-1:0] coil, spark_pulse, busy, overdwell_err;

    int checks = 0;
    int errors = 0;

    ign_sched_multi #(.MAX_DWELL(MAXD)) dut (
        .clk              (clk),
        .reset            (reset),
        .trigger          (trigger),
        .eng_phase        (eng_phase),
        .next_tooth_width (next_tooth_width),
        .tooth_period     (tooth_period),
        .timing           (timing),
        .dwell_cycles     (dwell_cycles),
        .ch_enable        (ch_enable),
        .coil             (coil),
        .spark_pulse      (spark_pulse),
        .busy             (busy),
        .overdwell_err    (overdwell_err)
    );

    always #5 clk = ~clk;

    // Reference model: each armed channel is a set of absolute cycle numbers
    // (busy start, coil on, first coil-low) derived from the arithmetic rules.
    longint unsigned cyc = 0;
    longint unsigned m_start [NCH];
    longint unsigned m_on    [NCH];
    longint unsigned m_off   [NCH];
    bit              m_pulse [NCH];
    bit              m_err   [NCH];
    logic [NCH-1:0]  exp_coil = '0, exp_spark = '0, exp_busy = '0, exp_err = '0;

    function automatic longint unsigned model_delay(input longint unsigned tp, input longint unsigned df);
        longint unsigned q;
        q = (tp * df) / 256;
        if (q < 4) return 0;
        q = q - 4;
        if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
        return q;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        longint unsigned tim, dw, d, w;
        bit active;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_start[i] = 0; m_on[i] = NEVER; m_off[i] = 0; m_pulse[i] = 0; m_err[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tim = timing[i*PW +: PW];
                dw  = dwell_cycles[i*TW +: TW];
                active = (m_start[i] <= cyc) && (cyc < m_off[i]);
                if (active && !ch_enable[i]) begin
                    m_pulse[i] = (cyc >= m_on[i]);
                    m_off[i]   = cyc + 1;
                    m_on[i]    = NEVER;
                end else if (!active && trigger && ch_enable[i] && tim > eng_phase &&
                             tim <= longint'(eng_phase) + longint'(next_tooth_width) + 20) begin
                    d = model_delay(tooth_period, tim - longint'(eng_phase));
                    w = (dw > MAXD) ? MAXD : dw;
                    if (dw > MAXD) m_err[i] = 1;
                    m_start[i] = cyc + 1;
                    m_off[i]   = cyc + 1 + d;
                    m_on[i]    = (d > w) ? cyc + 1 + d - w : cyc + 1;
                    m_pulse[i] = 1;
                end
            end
            cyc = cyc + 1;
        end
        for (int i = 0; i < NCH; i++) begin
            exp_coil[i]  = (m_on[i] <= cyc) && (cyc < m_off[i]);
            exp_spark[i] = m_pulse[i] && (cyc == m_off[i]);
            exp_busy[i]  = (m_start[i] <= cyc) && (cyc < m_off[i]);
            exp_err[i]   = m_err[i];
        end
    end

    task automatic fire();
        @(negedge clk);
        trigger = 1'b1;
        @(posedge clk);
        #1 trigger = 1'b0;
    endtask

    task automatic setup_nominal();
        tooth_period = 32'd1000;
        eng_phase = 16'd200;
        next_tooth_width = 16'd150;
        timing = '0;
        timing[0 +: PW] = 16'd300;
        dwell_cycles = '0;
        dwell_cycles[0 +: TW] = 32'd100;
        ch_enable = 4'b0001;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({coil, spark_pulse, busy, overdwell_err} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0000", {coil, spark_pulse, busy, overdwell_err});
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy, overdwell_err} !== 16'h0000) begin
                errors++;
                $display("FAIL reset_idle got=%h exp=0000", {coil, spark_pulse, busy, overdwell_err});
            end
        end
    endtask

    task automatic test_nominal();
        int first_on = -1, spark_at = -1, n_high = 0, busy_end = -1;
        setup_nominal();
        fire();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy, overdwell_err} !== {exp_coil, exp_spark, exp_busy, exp_err}) begin
                errors++;
                $display("FAIL nominal t+%0d got c/s/b/e=%b/%b/%b/%b exp=%b/%b/%b/%b", k,
                         coil, spark_pulse, busy, overdwell_err, exp_coil, exp_spark, exp_busy, exp_err);
            end
            if (coil[0]) begin n_high++; if (first_on < 0) first_on = k; end
            if (spark_pulse[0] && spark_at < 0) spark_at = k;
            if (!busy[0] && busy_end < 0) busy_end = k;
        end
        checks++;
        if (first_on != 287 || n_high != 100 || spark_at != 387 || busy_end != 387) begin
            errors++;
            $display("FAIL nominal_edges got on=%0d high=%0d spark=%0d busy_low=%0d exp on=287 high=100 spark=387 busy_low=387",
                     first_on, n_high, spark_at, busy_end);
        end
    endtask

    task automatic test_window_miss();
        int act = 0;
        setup_nominal();
        timing[0 +: PW] = 16'd400;
        fire();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy} !== {exp_coil, exp_spark, exp_busy}) begin
                errors++;
                $display("FAIL window_miss t+%0d got c/s/b=%b/%b/%b exp=%b/%b/%b", k,
                         coil, spark_pulse, busy, exp_coil, exp_spark, exp_busy);
            end
            act += int'(coil[0]) + int'(spark_pulse[0]) + int'(busy[0]);
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL window_miss_activity got=%0d exp=0", act); end
    endtask

    task automatic test_short_dwell();
        int first_on = -1, n_high = 0, spark_at = -1;
        setup_nominal();
        dwell_cycles[0 +: TW] = 32'd500;
        fire();
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy, overdwell_err} !== {exp_coil, exp_spark, exp_busy, exp_err}) begin
                errors++;
                $display("FAIL short_dwell t+%0d got c/s/b/e=%b/%b/%b/%b exp=%b/%b/%b/%b", k,
                         coil, spark_pulse, busy, overdwell_err, exp_coil, exp_spark, exp_busy, exp_err);
            end
            if (coil[0]) begin n_high++; if (first_on < 0) first_on = k; end
            if (spark_pulse[0] && spark_at < 0) spark_at = k;
        end
        checks++;
        if (first_on != 1 || n_high != 386 || spark_at != 387) begin
            errors++;
            $display("FAIL short_dwell_edges got on=%0d high=%0d spark=%0d exp on=1 high=386 spark=387",
                     first_on, n_high, spark_at);
        end
    endtask

    task automatic test_multi_retrigger();
        int s0 = -1, s1 = -1, on1 = -1, n_s0 = 0;
        setup_nominal();
        timing[1*PW +: PW] = 16'd330;
        dwell_cycles[1*TW +: TW] = 32'd100;
        ch_enable = 4'b0011;
        fire();
        for (int k = 1; k <= 520; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy, overdwell_err} !== {exp_coil, exp_spark, exp_busy, exp_err}) begin
                errors++;
                $display("FAIL multi t+%0d got c/s/b/e=%b/%b/%b/%b exp=%b/%b/%b/%b", k,
                         coil, spark_pulse, busy, overdwell_err, exp_coil, exp_spark, exp_busy, exp_err);
            end
            if (spark_pulse[0]) begin n_s0++; if (s0 < 0) s0 = k; end
            if (spark_pulse[1] && s1 < 0) s1 = k;
            if (coil[1] && on1 < 0) on1 = k;
            trigger = (k == 50);
            if (k == 50) timing[0 +: PW] = 16'd320;
        end
        trigger = 1'b0;
        checks++;
        if (s0 != 387 || n_s0 != 1 || on1 != 404 || s1 != 504) begin
            errors++;
            $display("FAIL multi_edges got s0=%0d n_s0=%0d on1=%0d s1=%0d exp s0=387 n_s0=1 on1=404 s1=504",
                     s0, n_s0, on1, s1);
        end
    endtask

    task automatic test_enable_drop();
        int n_high, n_spark, spark_at;
        for (int phase = 0; phase < 2; phase++) begin
            n_high = 0; n_spark = 0; spark_at = -1;
            setup_nominal();
            fire();
            for (int k = 1; k <= 400; k++) begin
                @(negedge clk);
                checks++;
                if ({coil, spark_pulse, busy} !== {exp_coil, exp_spark, exp_busy}) begin
                    errors++;
                    $display("FAIL enable_drop%0d t+%0d got c/s/b=%b/%b/%b exp=%b/%b/%b", phase, k,
                             coil, spark_pulse, busy, exp_coil, exp_spark, exp_busy);
                end
                if (coil[0]) n_high++;
                if (spark_pulse[0]) begin n_spark++; if (spark_at < 0) spark_at = k; end
                if (k == (phase == 0 ? 100 : 300)) ch_enable = 4'b0000;
            end
            checks++;
            if (phase == 0 && (n_high != 0 || n_spark != 0)) begin
                errors++;
                $display("FAIL drop_in_wait got high=%0d sparks=%0d exp high=0 sparks=0", n_high, n_spark);
            end else if (phase == 1 && (n_high != 14 || n_spark != 1 || spark_at != 301)) begin
                errors++;
                $display("FAIL drop_in_dwell got high=%0d sparks=%0d at=%0d exp high=14 sparks=1 at=301",
                         n_high, n_spark, spark_at);
            end
        end
    endtask

    task automatic test_saturation();
        int n_spark = 0, spark_at = -1, n_busy = 0;
        // 2^28+30 cycles over 4096 quanta: scaled delay just above 2^32, must not wrap.
        tooth_period = 32'h1000_001E;
        eng_phase = 16'd0;
        next_tooth_width = 16'd4096;
        timing = '0;
        timing[0 +: PW] = 16'd4096;
        dwell_cycles = '0;
        dwell_cycles[0 +: TW] = 32'd100;
        ch_enable = 4'b0001;
        fire();
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy} !== {exp_coil, exp_spark, exp_busy}) begin
                errors++;
                $display("FAIL sat_nowrap t+%0d got c/s/b=%b/%b/%b exp=%b/%b/%b", k,
                         coil, spark_pulse, busy, exp_coil, exp_spark, exp_busy);
            end
            n_spark += int'(spark_pulse[0]);
        end
        checks++;
        if (busy[0] !== 1'b1 || n_spark != 0) begin
            errors++;
            $display("FAIL sat_nowrap_state got busy=%b sparks=%0d exp busy=1 sparks=0", busy[0], n_spark);
        end
        ch_enable = 4'b0000;
        repeat (2) @(negedge clk);
        tooth_period = 32'hFFFF_FFFF;
        next_tooth_width = 16'hFFFF;
        timing[0 +: PW] = 16'hFFFF;
        ch_enable = 4'b0001;
        fire();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy} !== {exp_coil, exp_spark, exp_busy} || busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL sat_max t+%0d got c/s/b=%b/%b/%b exp=%b/%b/%b", k,
                         coil, spark_pulse, busy, exp_coil, exp_spark, exp_busy);
            end
        end
        ch_enable = 4'b0000;
        repeat (2) @(negedge clk);
        tooth_period = 32'd1;
        eng_phase = 16'd10;
        next_tooth_width = 16'd10;
        timing[0 +: PW] = 16'd11;
        ch_enable = 4'b0001;
        fire();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy} !== {exp_coil, exp_spark, exp_busy}) begin
                errors++;
                $display("FAIL sat_zero t+%0d got c/s/b=%b/%b/%b exp=%b/%b/%b", k,
                         coil, spark_pulse, busy, exp_coil, exp_spark, exp_busy);
            end
            if (spark_pulse[0] && spark_at < 0) spark_at = k;
            n_busy += int'(busy[0]) + int'(coil[0]);
        end
        checks++;
        if (spark_at != 1 || n_busy != 0) begin
            errors++;
            $display("FAIL sat_zero_edges got spark=%0d busy+coil=%0d exp spark=1 busy+coil=0", spark_at, n_busy);
        end
    endtask

    task automatic test_clamp();
        int first_on = -1, n_high = 0, spark_at = -1;
        setup_nominal();
        tooth_period = 32'd4000;
        dwell_cycles[0 +: TW] = 32'd1500;
        fire();
        for (int k = 1; k <= 1600; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy, overdwell_err} !== {exp_coil, exp_spark, exp_busy, exp_err}) begin
                errors++;
                $display("FAIL clamp t+%0d got c/s/b/e=%b/%b/%b/%b exp=%b/%b/%b/%b", k,
                         coil, spark_pulse, busy, overdwell_err, exp_coil, exp_spark, exp_busy, exp_err);
            end
            if (coil[0]) begin n_high++; if (first_on < 0) first_on = k; end
            if (spark_pulse[0] && spark_at < 0) spark_at = k;
        end
        checks++;
        if (first_on != 559 || n_high != 1000 || spark_at != 1559 || overdwell_err !== 4'b0001) begin
            errors++;
            $display("FAIL clamp_edges got on=%0d high=%0d spark=%0d err=%b exp on=559 high=1000 spark=1559 err=0001",
                     first_on, n_high, spark_at, overdwell_err);
        end
    endtask

    task automatic test_reset_mid_dwell();
        int n_spark = 0;
        setup_nominal();
        fire();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy} !== {exp_coil, exp_spark, exp_busy}) begin
                errors++;
                $display("FAIL rst_mid_pre t+%0d got c/s/b=%b/%b/%b exp=%b/%b/%b", k,
                         coil, spark_pulse, busy, exp_coil, exp_spark, exp_busy);
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({coil, spark_pulse, busy, overdwell_err} !== 16'h0000) begin
            errors++;
            $display("FAIL rst_async got c/s/b/e=%b/%b/%b/%b exp=0/0/0/0", coil, spark_pulse, busy, overdwell_err);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if ({coil, spark_pulse, busy, overdwell_err} !== {exp_coil, exp_spark, exp_busy, exp_err}) begin
                errors++;
                $display("FAIL rst_mid_post k=%0d got c/s/b/e=%b/%b/%b/%b exp=%b/%b/%b/%b", k,
                         coil, spark_pulse, busy, overdwell_err, exp_coil, exp_spark, exp_busy, exp_err);
            end
            n_spark += int'(spark_pulse[0]);
        end
        checks++;
        if (n_spark != 0) begin errors++; $display("FAIL rst_no_spark got=%0d exp=0", n_spark); end
    endtask

    task automatic test_random();
        int drop_at;
        logic [NCH-1:0] drop_mask;
        bit done;
        for (int it = 0; it < 16; it++) begin
            tooth_period = TW'($urandom_range(1, 1500));
            eng_phase = PW'($urandom_range(0, 60000));
            next_tooth_width = PW'($urandom_range(0, 300));
            for (int c = 0; c < NCH; c++) begin
                timing[c*PW +: PW] = eng_phase + PW'($urandom_range(0, 350)) - PW'(10);
                dwell_cycles[c*TW +: TW] = TW'($urandom_range(0, 1500));
            end
            ch_enable = NCH'($urandom);
            drop_at = $urandom_range(1, 900);
            drop_mask = NCH'($urandom);
            done = 0;
            fire();
            for (int k = 1; k <= 3000 && !done; k++) begin
                @(negedge clk);
                checks++;
                if ({coil, spark_pulse, busy, overdwell_err} !== {exp_coil, exp_spark, exp_busy, exp_err}) begin
                    errors++;
                    $display("FAIL random it=%0d t+%0d got c/s/b/e=%b/%b/%b/%b exp=%b/%b/%b/%b", it, k,
                             coil, spark_pulse, busy, overdwell_err, exp_coil, exp_spark, exp_busy, exp_err);
                end
                if (k == drop_at) ch_enable = ch_enable & ~drop_mask;
                if (busy == '0 && exp_busy == '0 && spark_pulse == '0 && exp_spark == '0) done = 1;
            end
            checks++;
            if (!done) begin errors++; $display("FAIL random_timeout it=%0d got busy=%b exp=0000", it, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_window_miss();
        test_short_dwell();
        test_multi_retrigger();
        test_enable_drop();
        test_saturation();
        test_clamp();
        test_reset_mid_dwell();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
